uart_tx_dev: RTL

Memory-mapped UART transmitter that sits on the data side of the processor, downstream of the Bridge next to the two timer counters. Stores from `mips` at its word slot push bytes into a small FIFO, which a serialiser drives out as 8N1 frames. Its interrupt output feeds the external `interrupt` input, so that line becomes HWInt[2] in CP0.

---
 rtl/uart_tx_dev_pkg.sv | 24 ++
 rtl/uart_tx_dev_fifo.sv | 58 +++++
 rtl/uart_tx_dev.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_dev_pkg.sv
// Shared constants for the memory-mapped UART transmitter: base address, register
// offsets, serialiser state encoding and the bit-period helper.
package uart_tx_dev_pkg;

  localparam logic [31:0] UART_BASE = 32'h0000_7f20;

  localparam logic [1:0] UART_CTRL = 2'd0;
  localparam logic [1:0] UART_DATA = 2'd1;
  localparam logic [1:0] UART_STAT = 2'd2;
  localparam logic [1:0] UART_DIV  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Bit-timer reload value (P-1); a divisor of 0 behaves like 1.
  function automatic logic [15:0] period_m1(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/uart_tx_dev_fifo.sv
// Synchronous transmit FIFO with simultaneous push/pop; occupancy is kept in a
// separate counter so full/empty never depend on pointer comparison.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [3:0]       count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == 4'd0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = push & (~full | w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: CTRL/DATA/STATUS/DIVISOR registers, a small
// transmit FIFO and a serialiser FSM, with a level interrupt when drained and idle.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  output logic        tx
);

  logic        r_en;
  logic        r_ie;
  logic        r_ovf;
  logic [15:0] r_div;
  tx_state_e   r_state;
  logic [7:0]  r_shift;
  logic [15:0] r_timer;
  logic [15:0] r_reload;
  logic [2:0]  r_bit_idx;
  logic        r_tx;

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_count;
  logic [7:0]  w_head;
  logic        w_overflow;
  logic        w_busy;
  logic        w_unused;

  assign w_unused   = ^din[31:16];
  assign w_push     = we & (addr == UART_DATA);
  assign w_pop      = r_en & ~w_empty &
                      ((r_state == ST_IDLE) | ((r_state == ST_STOP) & (r_timer == 16'd0)));
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_busy     = (r_state != ST_IDLE);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (din[7:0]),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
      r_div <= DEFAULT_DIV;
    end else begin
      if (we) begin
        case (addr)
          UART_CTRL: begin
            r_en <= din[0];
            r_ie <= din[1];
          end
          UART_STAT: r_ovf <= 1'b0;
          UART_DIV:  r_div <= din[15:0];
          default:   ;
        endcase
      end
      if (w_overflow) r_ovf <= 1'b1;
    end
  end

  // The period is latched at each pop, so DIVISOR writes only affect later frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'd0;
      r_timer   <= 16'd0;
      r_reload  <= 16'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_reload <= period_m1(r_div);
            r_timer  <= period_m1(r_div);
            r_tx     <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (r_timer == 16'd0) begin
            r_timer   <= r_reload;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (r_timer == 16'd0) begin
            r_timer <= r_reload;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        ST_STOP: begin
          if (r_timer == 16'd0) begin
            if (w_pop) begin
              r_shift  <= w_head;
              r_reload <= period_m1(r_div);
              r_timer  <= period_m1(r_div);
              r_tx     <= 1'b0;
              r_state  <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_ie & w_empty & ~w_busy;

  // NOTE: the default assignment ahead of the case keeps this block purely combinational.
  always_comb begin
    dout = 32'd0;
    case (addr)
      UART_CTRL: dout = {30'd0, r_ie, r_en};
      UART_STAT: dout = {24'd0, w_count, r_ovf, w_empty, w_full, w_busy};
      UART_DIV:  dout = {16'd0, r_div};
      default:   dout = 32'd0;
    endcase
  end

endmodule
